// File: rtl/exe_stage.sv
// Execute stage with EXE/MEM pipeline register.
// Define EXE_MUL_EN to build the iterative multi-cycle multiplier (opcode 1100).
module exe_stage #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic [4:0]  edestReg,
  input  logic [31:0] eqa,
  input  logic [31:0] eqb,
  input  logic [31:0] eimm32,
  output logic        estall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mdestReg,
  output logic [31:0] malu,
  output logic [31:0] mqb
);

  localparam logic [3:0] OP_MUL = 4'b1100;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
    $error("exe_stage: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [31:0] b_s;
  logic [31:0] alu_s;
  logic [31:0] result_s;
  logic        estall_s;
  logic        bubble_s;

  // Operand B mux
  always_comb begin
    b_s = ealuimm ? eimm32 : eqb;
  end

  // Single-cycle ALU; MUL is never produced here
  always_comb begin
    alu_s = 32'd0;
    case (ealuc)
      4'b0000: alu_s = eqa + b_s;
      4'b0001: alu_s = eqa - b_s;
      4'b0010: alu_s = eqa & b_s;
      4'b0011: alu_s = eqa | b_s;
      4'b0100: alu_s = eqa ^ b_s;
      4'b0101: alu_s = b_s << eqa[4:0];
      4'b0110: alu_s = b_s >> eqa[4:0];
      4'b0111: alu_s = $signed(b_s) >>> eqa[4:0];
      4'b1000: alu_s = ($signed(eqa) < $signed(b_s)) ? 32'd1 : 32'd0;
      4'b1001: alu_s = (eqa < b_s) ? 32'd1 : 32'd0;
      4'b1010: alu_s = {b_s[15:0], 16'd0};
      default: alu_s = 32'd0;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam int         NCHUNK = 32 / BITS_PER_CYCLE;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_r;
  logic [31:0] acc_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic [5:0]  count_r;
  logic [31:0] partial_s;

  // Sum of partial products for the low BITS_PER_CYCLE multiplier bits
  always_comb begin
    partial_s = 32'd0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_r[j]) begin
        partial_s = partial_s + (mcand_r << j);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  // Stall while a multiply is being accepted or iterated; reset forces it low
  always_comb begin
    estall_s = clrn && ((state_r == S_BUSY) || ((state_r == S_IDLE) && (ealuc == OP_MUL)));
    bubble_s = estall_s;
    result_s = (state_r == S_DONE) ? acc_r : alu_s;
  end

  // Multiply sequencer: IDLE loads operands, BUSY retires chunks, DONE hands off
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r  <= S_IDLE;
      acc_r    <= 32'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      count_r  <= 6'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ealuc == OP_MUL) begin
            mcand_r  <= eqa;
            mplier_r <= b_s;
            acc_r    <= 32'd0;
            count_r  <= 6'd0;
            state_r  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_r    <= acc_r + partial_s;
          mcand_r  <= mcand_r << BITS_PER_CYCLE;
          mplier_r <= mplier_r >> BITS_PER_CYCLE;
          count_r  <= count_r + 6'd1;
          if (count_r == 6'(NCHUNK - 1)) begin
            state_r <= S_DONE;
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end
`else
  // No multiplier: never stall, ALU result goes straight through
  always_comb begin
    estall_s = 1'b0;
    bubble_s = 1'b0;
    result_s = alu_s;
  end
`endif

  assign estall = estall_s;

  // EXE/MEM register; bubbles clear controls but keep data
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mdestReg <= 5'd0;
      malu     <= 32'd0;
      mqb      <= 32'd0;
    end else if (bubble_s) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mdestReg <= 5'd0;
    end else begin
      mwreg    <= ewreg;
      mm2reg   <= em2reg;
      mwmem    <= ewmem;
      mdestReg <= edestReg;
      malu     <= result_s;
      mqb      <= eqb;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: instruction-level reference model plus
// per-cycle compare of all outputs; honours EXE_MUL_EN if defined.
module tb_exe_stage;

`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int BPC = 1;

  logic        clk = 1'b0;
  logic        clrn;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  edestReg;
  logic [31:0] eqa, eqb, eimm32;
  logic        estall, mwreg, mm2reg, mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] malu, mqb;

  logic        exp_estall, exp_mwreg, exp_mm2reg, exp_mwmem;
  logic [4:0]  exp_mdest;
  logic [31:0] exp_malu, exp_mqb;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  bit check_en = 1'b0;

  exe_stage #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .clrn(clrn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealuimm(ealuimm), .edestReg(edestReg), .eqa(eqa),
    .eqb(eqb), .eimm32(eimm32), .estall(estall), .mwreg(mwreg),
    .mm2reg(mm2reg), .mwmem(mwmem), .mdestReg(mdestReg), .malu(malu), .mqb(mqb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(a % 32);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = b << s;
      4'd6:  r = b >> s;
      4'd7:  begin r = b >> s; if (b[31]) r = r | ~(32'hFFFFFFFF >> s); end
      4'd8:  r = (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = b * 32'd65536;
      4'd12: r = MUL_EN ? a * b : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("estall", {31'd0, estall}, {31'd0, exp_estall});
      chk("mwreg", {31'd0, mwreg}, {31'd0, exp_mwreg});
      chk("mm2reg", {31'd0, mm2reg}, {31'd0, exp_mm2reg});
      chk("mwmem", {31'd0, mwmem}, {31'd0, exp_mwmem});
      chk("mdestReg", {27'd0, mdestReg}, {27'd0, exp_mdest});
      chk("malu", malu, exp_malu);
      chk("mqb", mqb, exp_mqb);
      if (estall) stall_cnt++;
    end
  end

  task automatic run_instr(input logic wr, input logic m2r, input logic wm, input logic [3:0] op,
                           input logic imm, input logic [4:0] dst, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] i32);
    logic [31:0] res;
    ewreg = wr; em2reg = m2r; ewmem = wm; ealuc = op; ealuimm = imm;
    edestReg = dst; eqa = a; eqb = b; eimm32 = i32;
    res = model(op, a, imm ? i32 : b);
    if (MUL_EN && op == 4'b1100) begin
      for (int k = 0; k < 32 / BPC + 1; k++) begin
        exp_estall = 1'b1;
        @(posedge clk);
        exp_mwreg = 1'b0; exp_mm2reg = 1'b0; exp_mwmem = 1'b0; exp_mdest = 5'd0;
        #1;
      end
    end
    exp_estall = 1'b0;
    @(posedge clk);
    exp_mwreg = wr; exp_mm2reg = m2r; exp_mwmem = wm; exp_mdest = dst;
    exp_malu = res; exp_mqb = b;
    #1;
  endtask

  task automatic zero_exp();
    exp_estall = 1'b0; exp_mwreg = 1'b0; exp_mm2reg = 1'b0; exp_mwmem = 1'b0;
    exp_mdest = 5'd0; exp_malu = 32'd0; exp_mqb = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    clrn = 1'b1;
    ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0; ealuc = 4'd0; ealuimm = 1'b0;
    edestReg = 5'd0; eqa = 32'd0; eqb = 32'd0; eimm32 = 32'd0;
    zero_exp();
    #1 clrn = 1'b0;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_malu", malu, 32'd0);
    chk("reset_estall", {31'd0, estall}, 32'd0);
    clrn = 1'b1;

    run_instr(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 5'd5, 32'h10, 32'h0, 32'hFFFFFFFC);
    chk("tp_add_malu", malu, 32'h0000000C);
    chk("tp_add_mwreg", {31'd0, mwreg}, 32'd1);
    chk("tp_add_mdest", {27'd0, mdestReg}, 32'd5);
    run_instr(1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 5'd3, 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("tp_slt", malu, 32'd1);
    run_instr(1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, 5'd3, 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("tp_sltu", malu, 32'd0);
    run_instr(1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 5'd4, 32'd4, 32'h80000000, 32'd0);
    chk("tp_sra", malu, 32'hF8000000);
    run_instr(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 5'd0, 32'h100, 32'hDEADBEEF, 32'd8);
    chk("tp_store_malu", malu, 32'h108);
    chk("tp_store_mqb", mqb, 32'hDEADBEEF);
    chk("tp_store_mwmem", {31'd0, mwmem}, 32'd1);

    stall_cnt = 0;
    run_instr(1'b1, 1'b0, 1'b0, 4'b1100, 1'b0, 5'd7, 32'd7, 32'hFFFFFFFD, 32'd0);
    chk("tp_mul_stall_cycles", stall_cnt, MUL_EN ? 32'd33 : 32'd0);
    chk("tp_mul_malu", malu, MUL_EN ? 32'hFFFFFFEB : 32'd0);
    chk("tp_mul_mwreg", {31'd0, mwreg}, 32'd1);

    // back-to-back MUL, second one without register write
    run_instr(1'b1, 1'b0, 1'b0, 4'b1100, 1'b1, 5'd2, 32'h12345, 32'd0, 32'h1000);
    run_instr(1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 5'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    chk("mul_nowreg_malu", malu, MUL_EN ? 32'd1 : 32'd0);
    chk("mul_nowreg_mwreg", {31'd0, mwreg}, 32'd0);

    // reset 10 cycles into a MUL
    check_en = 1'b0;
    ewreg = 1'b1; ealuc = 4'b1100; ealuimm = 1'b0; eqa = 32'd3; eqb = 32'd5; edestReg = 5'd9;
    repeat (10) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("rst_mid_estall", {31'd0, estall}, 32'd0);
    chk("rst_mid_malu", malu, 32'd0);
    chk("rst_mid_mwreg", {31'd0, mwreg}, 32'd0);
    zero_exp();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    run_instr(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd11, 32'd20, 32'd22, 32'd0);
    chk("post_rst_add", malu, 32'd42);
    chk("post_rst_dest", {27'd0, mdestReg}, 32'd11);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'b1100 && $urandom_range(0, 2) != 0) op = 4'b0001;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 40));
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), op, 1'($urandom),
                5'($urandom), a, $urandom, $urandom);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
